// File: rtl/fma_issue_arbiter_pkg.sv
// Shared constants for the FMA issue arbiter and the FMA datapath it feeds.
// FMA_LATENCY_DEF is the single agreed latency value for both sides.
package fma_issue_arbiter_pkg;
    localparam int FMA_WIDTH       = 32;
    localparam int FMA_EXP_WIDTH   = 8;
    localparam int FMA_SIG_WIDTH   = 24;
    localparam int FMA_LATENCY_DEF = 9;
    localparam int CNT_W           = 4;

    typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/fma_issue_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after pointer wins.
module rr_arbiter #(
    parameter int N = 2,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [PW-1:0] pointer,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] nextPointer
);
    always_comb begin
        logic found;
        grant       = '0;
        nextPointer = pointer;
        found       = 1'b0;
        // k is the distance from the pointer; the nearest eligible index wins
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && eligible[i] && (i == (int'(pointer) + k) % N)) begin
                    grant[i]    = 1'b1;
                    nextPointer = PW'((i + 1) % N);
                    found       = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/fma_issue_arbiter.sv
// Round-robin issue of NUM_REQ requesters into one pipelined FMA, with an
// ownership shift register that steers each result back to its issuer.
module fma_issue_arbiter
    import fma_issue_arbiter_pkg::*;
#(
    parameter int WIDTH           = FMA_WIDTH,
    parameter int NUM_REQ         = 2,
    parameter int FMA_LATENCY     = FMA_LATENCY_DEF,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    input  logic [NUM_REQ*WIDTH-1:0]   req_c,
    output logic [WIDTH-1:0]           fma_a,
    output logic [WIDTH-1:0]           fma_b,
    output logic [WIDTH-1:0]           fma_c,
    output logic                       fma_in_valid,
    input  logic [WIDTH-1:0]           fma_res,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       busy
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    cnt_t [NUM_REQ-1:0]              cnt;
    logic [NUM_REQ-1:0]              eligible, grant, decV;
    logic [IDW-1:0]                  rrPtr, rrPtrNext, grantId, retId;
    logic [FMA_LATENCY:0]            vldPipe;
    logic [FMA_LATENCY:0][IDW-1:0]   idPipe;
    logic [WIDTH-1:0]                selA, selB, selC;
    logic                            anyGrant, retVld;

    // Counters are registered, so a same-cycle release never opens a slot
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++)
            eligible[i] = req_valid[i] && (cnt[i] < CNT_W'(MAX_OUTSTANDING));
    end

    rr_arbiter #(.N(NUM_REQ)) uArb (
        .eligible    (eligible),
        .pointer     (rrPtr),
        .grant       (grant),
        .nextPointer (rrPtrNext)
    );

    assign req_ready = grant;
    assign anyGrant  = |grant;

    always_comb begin
        grantId = '0;
        selA    = '0;
        selB    = '0;
        selC    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grantId = IDW'(i);
                selA    = req_a[i*WIDTH +: WIDTH];
                selB    = req_b[i*WIDTH +: WIDTH];
                selC    = req_c[i*WIDTH +: WIDTH];
            end
        end
    end

    // Stage 0 is the issue register itself; stage FMA_LATENCY lines up with fma_res
    assign fma_in_valid = vldPipe[0];
    assign retVld       = vldPipe[FMA_LATENCY];
    assign retId        = idPipe[FMA_LATENCY];

    always_comb begin
        decV = '0;
        for (int i = 0; i < NUM_REQ; i++)
            decV[i] = retVld && (retId == IDW'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fma_a     <= '0;
            fma_b     <= '0;
            fma_c     <= '0;
            rrPtr     <= '0;
            vldPipe   <= '0;
            idPipe    <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            cnt       <= '0;
        end else begin
            vldPipe   <= {vldPipe[FMA_LATENCY-1:0], anyGrant};
            idPipe    <= {idPipe[FMA_LATENCY-1:0], grantId};
            rsp_valid <= decV;
            if (anyGrant) begin
                fma_a <= selA;
                fma_b <= selB;
                fma_c <= selC;
                rrPtr <= rrPtrNext;
            end
            if (retVld)
                rsp_data <= fma_res;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i] && !decV[i])
                    cnt[i] <= cnt[i] + CNT_W'(1);
                else if (!grant[i] && decV[i])
                    cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    assign busy = (|vldPipe) || (|rsp_valid);

    for (genvar i = 0; i < NUM_REQ; i++) begin : gCntChk
        assert property (@(posedge clk) disable iff (!rst_n)
            !(grant[i] && !decV[i] && cnt[i] == '1) &&
            !(decV[i] && !grant[i] && cnt[i] == '0));
    end
endmodule

// File: tb/tb_fma_issue_arbiter.sv
// Directed bench: stand-in FMA delay line plus an expected-response queue
// built from the bench's own grant predictions.
module tb_fma_issue_arbiter;
    localparam int W       = 32;
    localparam int NR      = 2;
    localparam int LAT     = 9;
    localparam int RSP_LAT = LAT + 2;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a = '0, req_b = '0, req_c = '0;
    logic [W-1:0]      fma_a, fma_b, fma_c, fma_res, rsp_data;
    logic              fma_in_valid, busy;
    logic [NR-1:0]     rsp_valid;

    always #5 clk = ~clk;

    fma_issue_arbiter #(.WIDTH(W), .NUM_REQ(NR), .FMA_LATENCY(LAT), .MAX_OUTSTANDING(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_in_valid(fma_in_valid),
        .fma_res(fma_res),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
    );

    function automatic logic [W-1:0] fmaFn(input logic [W-1:0] a, b, c);
        if (a == 32'h3F800000 && b == 32'h40000000 && c == 32'h3F800000)
            return 32'h40400000;  // 1.0 * 2.0 + 1.0
        return (a ^ {b[15:0], b[31:16]}) + c;
    endfunction

    // Stand-in FMA: fixed-latency line; emits junk when idle so stale data is visible
    logic [W-1:0] fmaPipe [LAT];
    int cyc = 0;
    initial for (int i = 0; i < LAT; i++) fmaPipe[i] = '0;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) fmaPipe[i] <= fmaPipe[i-1];
        fmaPipe[0] <= fma_in_valid ? fmaFn(fma_a, fma_b, fma_c) : (32'hDEAD0000 | 32'(cyc[15:0]));
        cyc <= cyc + 1;
    end
    assign fma_res = fmaPipe[LAT-1];

    typedef struct { int due; int id; logic [W-1:0] data; } exp_t;
    exp_t q[$];

    int nTests = 0, nFail = 0;
    logic [W-1:0] opA [NR], opB [NR], opC [NR];
    logic [W-1:0] lastA = '0, lastB = '0, lastC = '0, lastRsp = '0;
    logic issPend = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic setOps(input int k);
        for (int i = 0; i < NR; i++) begin
            opA[i] = 32'h1000_0000 * (i + 1) + 32'(k);
            opB[i] = 32'h0002_0000 + 32'(k * 3) + 32'(i);
            opC[i] = 32'hC000_0000 | 32'(k << 8) | 32'(i);
        end
    endtask

    // One cycle: drive, check everything at negedge, record the expected issue
    task automatic step(input logic [NR-1:0] vld, input logic [NR-1:0] expRdy);
        logic expBusy;
        logic [NR-1:0] oh;
        int gid;
        exp_t e;
        req_valid = vld;
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = opA[i];
            req_b[i*W +: W] = opB[i];
            req_c[i*W +: W] = opC[i];
        end
        @(negedge clk);
        expBusy = (q.size() != 0);
        chk("fma_in_valid", 64'(fma_in_valid), 64'(issPend));
        chk("fma_a", 64'(fma_a), 64'(lastA));
        chk("fma_b", 64'(fma_b), 64'(lastB));
        chk("fma_c", 64'(fma_c), 64'(lastC));
        if (q.size() != 0 && q[0].due == cyc) begin
            oh = '0;
            oh[q[0].id] = 1'b1;
            chk("rsp_valid", 64'(rsp_valid), 64'(oh));
            chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
            lastRsp = q[0].data;
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'(0));
            chk("rsp_hold", 64'(rsp_data), 64'(lastRsp));
        end
        chk("busy", 64'(busy), 64'(expBusy));
        chk("req_ready", 64'(req_ready), 64'(expRdy));
        if (expRdy != '0) begin
            gid = 0;
            for (int i = 0; i < NR; i++) if (expRdy[i]) gid = i;
            e.due  = cyc + RSP_LAT;
            e.id   = gid;
            e.data = fmaFn(opA[gid], opB[gid], opC[gid]);
            q.push_back(e);
            lastA = opA[gid];
            lastB = opB[gid];
            lastC = opC[gid];
            issPend = 1'b1;
        end else begin
            issPend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        setOps(0);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_fma_in_valid", 64'(fma_in_valid), 0);
        chk("rst_rsp_valid", 64'(rsp_valid), 0);
        chk("rst_rsp_data", 64'(rsp_data), 0);
        chk("rst_fma_a", 64'(fma_a), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_req_ready", 64'(req_ready), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single issue from requester 0; response 11 cycles after accept
        opA[0] = 32'h3F800000; opB[0] = 32'h40000000; opC[0] = 32'h3F800000;
        step(2'b01, 2'b01);
        repeat (12) step(2'b00, 2'b00);

        // contention: pointer is 1 after the grant to 0
        for (int k = 0; k < 6; k++) begin
            setOps(100 + k);
            step(2'b11, (k % 2 == 0) ? 2'b10 : 2'b01);
        end
        repeat (14) step(2'b00, 2'b00);

        // credit limit: 4 grants, stall, then one grant per release
        for (int j = 0; j < 16; j++) begin
            setOps(200 + j);
            step(2'b01, (j < 4 || (j >= 11 && j <= 14)) ? 2'b01 : 2'b00);
        end
        repeat (14) step(2'b00, 2'b00);

        // idle: operand registers and rsp_data hold
        repeat (20) step(2'b00, 2'b00);

        // reset mid-flight
        for (int k = 0; k < 3; k++) begin
            setOps(300 + k);
            step(2'b01, 2'b01);
        end
        step(2'b00, 2'b00);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_fma_in_valid", 64'(fma_in_valid), 0);
        chk("mid_rst_fma_a", 64'(fma_a), 0);
        chk("mid_rst_fma_b", 64'(fma_b), 0);
        chk("mid_rst_fma_c", 64'(fma_c), 0);
        chk("mid_rst_rsp_valid", 64'(rsp_valid), 0);
        chk("mid_rst_rsp_data", 64'(rsp_data), 0);
        chk("mid_rst_busy", 64'(busy), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        q.delete();
        issPend = 1'b0;
        lastA = '0; lastB = '0; lastC = '0; lastRsp = '0;
        repeat (15) step(2'b00, 2'b00);

        // pointer back at 0: requester 0 wins first
        setOps(400);
        step(2'b11, 2'b01);
        setOps(401);
        step(2'b11, 2'b10);
        repeat (13) step(2'b00, 2'b00);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/fma_issue_arbiter.md
Name: fma_issue_arbiter

Overview:
- Shares one fixed-latency pipelined FMA datapath (unpack -> multiply -> align -> add -> normalize/round) between NUM_REQ requesters.
- Arbitrates issue round-robin with a valid/ready handshake and registers the A/B/C operands into the FMA.
- Tracks the owner of every in-flight operation in a shift register aligned to the FMA pipeline, and steers each result back to its owner.
- Sits between the requester-side scheduling logic and the FMA top.

Parameters:
- WIDTH, 32, operand/result width in bits; must match the WIDTH constant from parameters.v.
- NUM_REQ, 2, number of requesters (2..8).
- FMA_LATENCY, 9, cycles from fma_in_valid to the matching fma_res.
- MAX_OUTSTANDING, 4, maximum in-flight operations per requester (1..15).

Ports:
- clk  input  1  single clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  NUM_REQ*WIDTH  operand A per requester; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NUM_REQ*WIDTH  operand B, same packing as req_a.
- req_c  input  NUM_REQ*WIDTH  addend C, same packing as req_a.
- fma_a  output  WIDTH  registered operand A to the FMA.
- fma_b  output  WIDTH  registered operand B to the FMA.
- fma_c  output  WIDTH  registered addend C to the FMA.
- fma_in_valid  output  1  registered issue strobe to the FMA.
- fma_res  input  WIDTH  FMA result, valid FMA_LATENCY cycles after fma_in_valid.
- rsp_valid  output  NUM_REQ  registered one-hot result strobe; requesters must accept it unconditionally.
- rsp_data  output  WIDTH  registered result.
- busy  output  1  high while any operation is in flight or being returned.

Behaviour:
- Reset: asynchronous, active-low. On assertion, clear all of the following immediately:
  - fma_a/b/c, fma_in_valid, rsp_valid, rsp_data;
  - ownership pipeline, outstanding counters, round-robin pointer (pointer resets to 0).
- Reset mid-operation: in-flight results are discarded. No rsp_valid follows reset, even if fma_res later carries data.
- Eligibility: requester i is eligible when req_valid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- Arbitration:
  - Combinational round-robin starting at the pointer; the first eligible requester gets req_ready[i]=1.
  - req_ready never asserts for an ineligible requester.
  - req_ready may depend on req_valid; requesters must not make req_valid depend on req_ready.
- Pointer update: after a grant to i, the pointer becomes (i+1) mod NUM_REQ. With no grant, the pointer holds.
- Issue: on a handshake in cycle t, the chosen operands are registered and fma_in_valid=1 in cycle t+1. With no grant, fma_in_valid=0 and fma_a/b/c hold their previous values.
- Ownership pipeline:
  - FMA_LATENCY-stage shift of {valid, id[$clog2(NUM_REQ)-1:0]}, entering alongside fma_in_valid.
  - Stage output is valid exactly in the cycle fma_res is valid, i.e. t+1+FMA_LATENCY.
- Return:
  - In cycle t+2+FMA_LATENCY: rsp_valid[id]=1 and rsp_data = registered fma_res.
  - Total accept-to-response latency is FMA_LATENCY+2 cycles.
  - When no response is pending, rsp_valid=0 and rsp_data holds.
- Throughput: one issue per cycle. Back-to-back issues produce back-to-back responses in issue order.
- Counters: cnt[i] is 4 bits.
  - Increments on grant to i; decrements when the ownership pipeline output carries id i.
  - Both in the same cycle: unchanged.
  - Saturation is impossible by construction; an assertion flags overflow or underflow.
- Simultaneous release and request: a decrement does not create same-cycle eligibility. A requester at MAX_OUTSTANDING becomes eligible the cycle after its counter drops.
- busy = OR of: ownership pipeline valids, fma_in_valid, any rsp_valid.

Decomposition:
- Constants come from the shared parameters.v include: WIDTH, EXP_WIDTH, SIG_WIDTH.
- FMA_LATENCY is added to the same include, so the FMA top and this block agree on one value.
- Sub-module rr_arbiter (parameter N): inputs eligible[N], pointer; outputs grant one-hot and next pointer. Purely combinational, reusable.
- The ownership shift register and counters stay in the top module.

Test Plan:
- Single issue: req_valid=01, A=0x3F800000, B=0x40000000, C=0x3F800000 at cycle 5 -> fma_in_valid at cycle 6; rsp_valid=01, rsp_data=fma_res (0x40400000 from FMA model) at cycle 16.
- Contention: both requesters continuously valid -> grants alternate 0,1,0,1; each response returns to the correct owner in issue order; fma_in_valid stays high every cycle.
- Credit limit: requester 0 alone, MAX_OUTSTANDING=4, valid held -> exactly 4 grants (cycles 0-3), req_ready[0]=0 until the first response decrements cnt, then exactly one grant per response.
- Simultaneous grant and release: cnt[0]=3, a response to 0 and a grant to 0 in the same cycle -> cnt stays 3, no assertion.
- Reset mid-flight: issue 3 ops, deassert rst_n 4 cycles later for 2 cycles -> all outputs 0 immediately, no rsp_valid afterwards, busy=0, pointer=0.
- Idle: no req_valid for 20 cycles -> fma_in_valid=0, rsp_valid=0, busy=0, operand registers unchanged.
